// File: rtl/draw_menu_label_if.sv
// VGA timing/colour bus shared by the menu overlay stages.
// One producer modport and one consumer modport.
interface vga_bus;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        hblnk;
  logic        vsync;
  logic        vblnk;
  logic [11:0] rgb;

  modport in (
    input hcount, vcount, hsync, hblnk,
    input vsync, vblnk, rgb
  );

  modport out (
    output hcount, vcount, hsync, hblnk,
    output vsync, vblnk, rgb
  );
endinterface

// File: rtl/draw_menu_label.sv
// Menu caption overlay: draws a blinking "BOARD SIZE" label
// from the shared font ROM, 2-cycle pipeline on the VGA bus.
module draw_menu_label #(
  parameter int          LABEL_X      = 432,
  parameter int          LABEL_Y      = 352,
  parameter logic [11:0] FONT_COLOR   = 12'hfff,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_game_on,
  vga_bus.in          bus_in,
  vga_bus.out         bus_out,
  input  logic [15:0] char_pixels,
  output logic [10:0] address
);

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        hblnk;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;
  } bus_t;

  localparam logic [10:0] LX    = 11'(LABEL_X);
  localparam logic [10:0] LY    = 11'(LABEL_Y);
  localparam logic [11:0] LX_LO = 12'(LABEL_X);
  localparam logic [11:0] LX_HI = 12'(LABEL_X + 160);
  localparam logic [11:0] LY_LO = 12'(LABEL_Y);
  localparam logic [11:0] LY_HI = 12'(LABEL_Y + 16);
  localparam bit          BLINK_EN = (BLINK_FRAMES != 0);
  localparam logic [5:0]  BF_LAST  =
    6'((BLINK_FRAMES == 0) ? 0 : BLINK_FRAMES - 1);

  // ASCII code of each caption position
  function automatic logic [6:0] glyph_code(
    input logic [3:0] idx
  );
    logic [6:0] c;
    case (idx)
      4'd0:    c = 7'h42;
      4'd1:    c = 7'h4F;
      4'd2:    c = 7'h41;
      4'd3:    c = 7'h52;
      4'd4:    c = 7'h44;
      4'd5:    c = 7'h20;
      4'd6:    c = 7'h53;
      4'd7:    c = 7'h49;
      4'd8:    c = 7'h5A;
      4'd9:    c = 7'h45;
      default: c = 7'h20;
    endcase
    return c;
  endfunction

  bus_t        bus_w;
  logic [7:0]  hoff;
  logic [3:0]  voff;
  logic        in_label;

  bus_t        s1_q, s1_d;
  logic        in_label_q, in_label_d;
  logic [3:0]  col_q, col_d;
  logic [10:0] addr_q, addr_d;

  bus_t        out_q, out_d;
  logic        pix;

  logic        vsync_q, vsync_d;
  logic [5:0]  frame_cnt_q, frame_cnt_d;
  logic        visible_q, visible_d;
  logic        frame_tick;

  // Gather the incoming bus and locate the pixel in the label
  always_comb begin
    bus_w.hcount = bus_in.hcount;
    bus_w.vcount = bus_in.vcount;
    bus_w.hsync  = bus_in.hsync;
    bus_w.hblnk  = bus_in.hblnk;
    bus_w.vsync  = bus_in.vsync;
    bus_w.vblnk  = bus_in.vblnk;
    bus_w.rgb    = bus_in.rgb;
    hoff = 8'(bus_in.hcount - LX);
    voff = 4'(bus_in.vcount - LY);
    in_label = ({1'b0, bus_in.hcount} >= LX_LO)
            && ({1'b0, bus_in.hcount} <  LX_HI)
            && ({1'b0, bus_in.vcount} >= LY_LO)
            && ({1'b0, bus_in.vcount} <  LY_HI);
  end

  // Stage 1 next state: delayed bus, ROM address, glyph column
  always_comb begin
    s1_d       = bus_w;
    in_label_d = in_label;
    col_d      = hoff[3:0];
    addr_d     = '0;
    if (in_label) begin
      addr_d = {glyph_code(hoff[7:4]), voff};
    end
  end

  // Stage 1 registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q       <= '0;
      in_label_q <= 1'b0;
      col_q      <= '0;
      addr_q     <= '0;
    end else begin
      s1_q       <= s1_d;
      in_label_q <= in_label_d;
      col_q      <= col_d;
      addr_q     <= addr_d;
    end
  end

  // Stage 2 next state: merge the glyph pixel into rgb
  always_comb begin
    pix   = char_pixels[4'd15 - col_q];
    out_d = s1_q;
    if (in_label_q && !is_game_on && visible_q && pix) begin
      out_d.rgb = FONT_COLOR;
    end
  end

  // Stage 2 registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  // Blink phase: count frames, flip visibility each phase
  always_comb begin
    frame_tick  = bus_in.vsync && !vsync_q;
    vsync_d     = bus_in.vsync;
    frame_cnt_d = frame_cnt_q;
    visible_d   = visible_q;
    if (is_game_on) begin
      frame_cnt_d = '0;
      visible_d   = 1'b1;
    end else if (BLINK_EN && frame_tick) begin
      if (frame_cnt_q == BF_LAST) begin
        frame_cnt_d = '0;
        visible_d   = !visible_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 6'd1;
      end
    end
  end

  // Blink state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_q     <= 1'b0;
      frame_cnt_q <= '0;
      visible_q   <= 1'b1;
    end else begin
      vsync_q     <= vsync_d;
      frame_cnt_q <= frame_cnt_d;
      visible_q   <= visible_d;
    end
  end

  assign bus_out.hcount = out_q.hcount;
  assign bus_out.vcount = out_q.vcount;
  assign bus_out.hsync  = out_q.hsync;
  assign bus_out.hblnk  = out_q.hblnk;
  assign bus_out.vsync  = out_q.vsync;
  assign bus_out.vblnk  = out_q.vblnk;
  assign bus_out.rgb    = out_q.rgb;
  assign address        = addr_q;

endmodule

// File: tb/tb_draw_menu_label.sv
// Bench for draw_menu_label: caption drawing, blink,
// suppression while in game, and asynchronous reset.
module tb_draw_menu_label;

  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        is_game_on = 1'b0;
  logic [15:0] char_pixels;
  logic [10:0] address;

  vga_bus bin ();
  vga_bus bout ();

  draw_menu_label #(
    .LABEL_X     (432),
    .LABEL_Y     (352),
    .FONT_COLOR  (12'hfff),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .is_game_on (is_game_on),
    .bus_in     (bin),
    .bus_out    (bout),
    .char_pixels(char_pixels),
    .address    (address)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        hb;
    logic        vs;
    logic        vb;
    logic [11:0] rgb;
    bit          vis;
  } rec_t;

  string label = "BOARD SIZE";
  int    rom_mode = 0;
  int    errors = 0;
  int    checks = 0;
  int    ticks = 0;
  bit    prev_vs = 0;
  rec_t  q[$];
  bit    exp_v;
  logic [37:0] exp_o;
  logic [37:0] obs_w;

  assign obs_w = {bout.hcount, bout.vcount, bout.hsync,
                  bout.hblnk, bout.vsync, bout.vblnk, bout.rgb};

  function automatic logic [15:0] rom(
    input logic [10:0] a, input int mode
  );
    case (mode)
      1:       return 16'h8000;
      2:       return 16'hffff;
      3:       return 16'h0001;
      default: return 16'(a * 16'd40503) ^ 16'h5a5a;
    endcase
  endfunction

  always_comb char_pixels = rom(address, rom_mode);

  function automatic logic [11:0] expect_rgb(
    input rec_t r, input bit game
  );
    int dx, dy;
    logic [7:0]  code;
    logic [10:0] a;
    logic [15:0] row;
    dx = int'(r.h) - 432;
    dy = int'(r.v) - 352;
    if (game || !r.vis) return r.rgb;
    if (dx < 0 || dx >= 160 || dy < 0 || dy >= 16)
      return r.rgb;
    code = label[dx / 16];
    a    = 11'(code * 16 + dy);
    row  = rom(a, rom_mode);
    return row[15 - dx % 16] ? 12'hfff : r.rgb;
  endfunction

  task automatic set_bus(
    input int h, input int v,
    input bit hs, input bit hb, input bit vs, input bit vb,
    input logic [11:0] rgb
  );
    bin.hcount = 11'(h);
    bin.vcount = 11'(v);
    bin.hsync  = hs;
    bin.hblnk  = hb;
    bin.vsync  = vs;
    bin.vblnk  = vb;
    bin.rgb    = rgb;
  endtask

  task automatic reset_model();
    ticks   = 0;
    prev_vs = 0;
    q.delete();
  endtask

  // Advance one clock; expected output of the input 2 cycles back
  task automatic cycle();
    rec_t r, r0;
    bit   tick;
    tick    = bin.vsync && !prev_vs;
    prev_vs = bin.vsync;
    if (is_game_on) ticks = 0;
    else if (tick) ticks++;
    r.h   = bin.hcount;
    r.v   = bin.vcount;
    r.hs  = bin.hsync;
    r.hb  = bin.hblnk;
    r.vs  = bin.vsync;
    r.vb  = bin.vblnk;
    r.rgb = bin.rgb;
    r.vis = (BF == 0) || ((ticks / BF) % 2 == 0);
    q.push_back(r);
    @(posedge clk);
    #1;
    exp_v = 0;
    if (q.size() == 2) begin
      r0    = q.pop_front();
      exp_o = {r0.h, r0.v, r0.hs, r0.hb, r0.vs, r0.vb,
               expect_rgb(r0, is_game_on)};
      exp_v = 1;
    end
  endtask

  task automatic test_reset();
    rst = 0;
    set_bus(5, 0, 0, 0, 0, 0, 12'h0a0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs_w !== '0) begin
      errors++;
      $display("FAIL reset_bus: got %h want 0", obs_w);
    end
    checks++;
    if (address !== '0) begin
      errors++;
      $display("FAIL reset_addr: got %h want 0", address);
    end
    rst = 1;
    reset_model();
    cycle();
    checks++;
    if (obs_w !== '0) begin
      errors++;
      $display("FAIL reset_fill1: got %h want 0", obs_w);
    end
    cycle();
    checks++;
    if (!exp_v || obs_w !== exp_o || bout.hcount !== 11'd5
        || bout.rgb !== 12'h0a0) begin
      errors++;
      $display("FAIL reset_fill2: got %h want hcount 5 rgb 0a0",
               obs_w);
    end
  endtask

  task automatic test_first_glyph();
    rom_mode = 1;
    q.delete();
    set_bus(432, 352, 0, 0, 0, 0, 12'h123);
    cycle();
    checks++;
    if (address !== 11'h420) begin
      errors++;
      $display("FAIL first_addr: got %h want 420", address);
    end
    set_bus(433, 352, 0, 0, 0, 0, 12'h456);
    cycle();
    checks++;
    if (!exp_v || obs_w !== exp_o || bout.rgb !== 12'hfff) begin
      errors++;
      $display("FAIL first_draw: got %h want rgb fff", obs_w);
    end
    set_bus(0, 0, 0, 0, 0, 0, 12'h789);
    cycle();
    checks++;
    if (!exp_v || obs_w !== exp_o || bout.rgb !== 12'h456) begin
      errors++;
      $display("FAIL first_pass: got %h want rgb 456", obs_w);
    end
  endtask

  task automatic test_last_glyph();
    rom_mode = 3;
    q.delete();
    set_bus(591, 367, 0, 0, 0, 0, 12'h111);
    cycle();
    checks++;
    if (address !== 11'h45F) begin
      errors++;
      $display("FAIL last_addr: got %h want 45f", address);
    end
    set_bus(592, 367, 0, 0, 0, 0, 12'h222);
    cycle();
    checks++;
    if (address !== 11'h000) begin
      errors++;
      $display("FAIL h_edge_addr: got %h want 0", address);
    end
    checks++;
    if (!exp_v || obs_w !== exp_o || bout.rgb !== 12'hfff) begin
      errors++;
      $display("FAIL last_draw: got %h want rgb fff", obs_w);
    end
    set_bus(591, 368, 0, 0, 0, 0, 12'h333);
    cycle();
    checks++;
    if (address !== 11'h000) begin
      errors++;
      $display("FAIL v_edge_addr: got %h want 0", address);
    end
    checks++;
    if (!exp_v || obs_w !== exp_o || bout.rgb !== 12'h222) begin
      errors++;
      $display("FAIL h_edge_pass: got %h want rgb 222", obs_w);
    end
    set_bus(0, 0, 0, 0, 0, 0, 12'h000);
    cycle();
    checks++;
    if (!exp_v || obs_w !== exp_o || bout.rgb !== 12'h333) begin
      errors++;
      $display("FAIL v_edge_pass: got %h want rgb 333", obs_w);
    end
  endtask

  task automatic test_game_on();
    rom_mode   = 2;
    is_game_on = 1;
    q.delete();
    for (int v = 351; v <= 368; v++) begin
      for (int h = 430; h <= 593; h++) begin
        set_bus(h, v, 0, 0, 0, 0, 12'($urandom_range(0, 12'hffe)));
        cycle();
        if (exp_v) begin
          checks++;
          if (obs_w !== exp_o || bout.rgb === 12'hfff) begin
            errors++;
            $display("FAIL game_on_hidden: got %h want %h",
                     obs_w, exp_o);
          end
        end
      end
    end
    set_bus(0, 0, 0, 0, 0, 0, 12'h000);
    cycle();
  endtask

  task automatic test_blink();
    bit seq [6] = '{1, 0, 0, 1, 1, 0};
    bit seq2 [2] = '{1, 0};
    logic [11:0] want;
    rom_mode   = 1;
    is_game_on = 0;
    q.delete();
    for (int n = 0; n < 6; n++) begin
      set_bus(0, 0, 0, 0, 1, 0, 12'h000); cycle();
      set_bus(0, 0, 0, 0, 0, 0, 12'h000); cycle();
      set_bus(432, 352, 0, 0, 0, 0, 12'h0f0); cycle();
      set_bus(0, 0, 0, 0, 0, 0, 12'h000); cycle();
      want = seq[n] ? 12'hfff : 12'h0f0;
      checks++;
      if (!exp_v || obs_w !== exp_o || bout.rgb !== want) begin
        errors++;
        $display("FAIL blink_tick%0d: got rgb %h want %h",
                 n + 1, bout.rgb, want);
      end
    end
    is_game_on = 1;
    cycle();
    cycle();
    is_game_on = 0;
    set_bus(432, 352, 0, 0, 0, 0, 12'h0f0); cycle();
    set_bus(0, 0, 0, 0, 0, 0, 12'h000); cycle();
    checks++;
    if (!exp_v || obs_w !== exp_o || bout.rgb !== 12'hfff) begin
      errors++;
      $display("FAIL blink_restore: got rgb %h want fff", bout.rgb);
    end
    for (int k = 0; k < 2; k++) begin
      set_bus(0, 0, 0, 0, 1, 0, 12'h000); cycle();
      set_bus(0, 0, 0, 0, 0, 0, 12'h000); cycle();
      set_bus(432, 352, 0, 0, 0, 0, 12'h0f0); cycle();
      set_bus(0, 0, 0, 0, 0, 0, 12'h000); cycle();
      want = seq2[k] ? 12'hfff : 12'h0f0;
      checks++;
      if (!exp_v || obs_w !== exp_o || bout.rgb !== want) begin
        errors++;
        $display("FAIL blink_restart%0d: got rgb %h want %h",
                 k + 1, bout.rgb, want);
      end
    end
  endtask

  task automatic test_async_reset();
    rom_mode = 1;
    q.delete();
    set_bus(440, 352, 1, 0, 0, 0, 12'habc);
    cycle();
    cycle();
    checks++;
    if (address !== 11'h420 || !exp_v || obs_w !== exp_o) begin
      errors++;
      $display("FAIL pre_reset: got addr %h bus %h want 420 %h",
               address, obs_w, exp_o);
    end
    #2;
    rst = 0;
    #1;
    checks++;
    if (obs_w !== '0) begin
      errors++;
      $display("FAIL async_bus: got %h want 0", obs_w);
    end
    checks++;
    if (address !== '0) begin
      errors++;
      $display("FAIL async_addr: got %h want 0", address);
    end
    rst = 1;
    reset_model();
    cycle();
    cycle();
    checks++;
    if (!exp_v || obs_w !== exp_o) begin
      errors++;
      $display("FAIL async_refill: got %h want %h", obs_w, exp_o);
    end
  endtask

  task automatic test_random();
    rom_mode = 0;
    q.delete();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) is_game_on = ~is_game_on;
      set_bus($urandom_range(420, 600), $urandom_range(348, 372),
              1'($urandom), 1'($urandom),
              ($urandom_range(0, 7) == 0), 1'($urandom),
              12'($urandom));
      cycle();
      if (exp_v) begin
        checks++;
        if (obs_w !== exp_o) begin
          errors++;
          $display("FAIL random_%0d: got %h want %h",
                   i, obs_w, exp_o);
        end
      end
    end
    is_game_on = 0;
  endtask

  initial begin
    test_reset();
    test_first_glyph();
    test_last_glyph();
    test_game_on();
    test_blink();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
